muldiv_unit: RTL and testbench

- Parametrised multi-cycle multiply/divide unit with HI/LO registers, sitting in the E stage beside the ALU.
- Driven by the 4-bit MD operation code from the decode controller.
- Generalises the fixed 32-bit, fixed-latency HI/LO unit in three ways: configurable width, independently configurable mult/div latencies, and an explicit busy/start handshake that the hazard unit uses for stalling.

---
 rtl/muldiv_unit.sv | 170 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multi-cycle multiply/divide unit with HI/LO registers
//
// Purpose:
//   E-stage multiply/divide unit. mult/multu/div/divu latch their operands and
//   run for a fixed, per-class number of cycles with busy asserted. Results are
//   written to HI/LO on the edge that ends the run. mtlo/mthi write directly
//   from D1 when the unit is idle. mflo/mfhi read through md_out.
//
// Ports:
//   clk     in   system clock
//   reset   in   synchronous, active-high reset
//   start   in   E-stage holds a valid MD-class instruction this cycle
//   md_op   in   [3:0]  0 mult, 1 multu, 2 div, 3 divu, 4 mtlo, 5 mthi,
//                       6 mflo, 7 mfhi, others none
//   D1      in   [WIDTH-1:0]  rs operand (dividend / multiplicand / mt source)
//   D2      in   [WIDTH-1:0]  rt operand (divisor / multiplier)
//   busy    out  multi-cycle operation in flight
//   HI      out  [WIDTH-1:0]  architectural HI register
//   LO      out  [WIDTH-1:0]  architectural LO register
//   md_out  out  [WIDTH-1:0]  mf read data (HI for md_op=7, LO otherwise)

module muldiv_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       md_op,
    input  logic [WIDTH-1:0] D1,
    input  logic [WIDTH-1:0] D2,
    output logic             busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic [WIDTH-1:0] md_out
);

    generate
        if (WIDTH < 2) begin : g_bad_width
            $error("muldiv_unit: WIDTH must be at least 2");
        end
        if (MULT_CYCLES < 1 || DIV_CYCLES < 1) begin : g_bad_latency
            $error("muldiv_unit: MULT_CYCLES and DIV_CYCLES must be at least 1");
        end
        if (MULT_CYCLES > (1 << CNT_W) - 1 || DIV_CYCLES > (1 << CNT_W) - 1) begin : g_bad_cnt
            $error("muldiv_unit: CNT_W too narrow for configured latencies");
        end
    endgenerate

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    logic               r_busy;
    logic [1:0]         r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    // op[0]=0 selects the signed flavour, op[1]=1 selects divide.
    logic               w_is_signed;
    logic               w_is_div;
    logic [2*WIDTH-1:0] w_ext_a;
    logic [2*WIDTH-1:0] w_ext_b;
    logic [2*WIDTH-1:0] w_prod;
    logic               w_neg_a;
    logic               w_neg_b;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic               w_b_zero;
    logic [WIDTH-1:0]   w_mag_b_safe;
    logic [WIDTH-1:0]   w_q_mag;
    logic [WIDTH-1:0]   w_r_mag;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;
    logic               w_md_start;
    logic [CNT_W-1:0]   w_run_len;
    logic [CNT_W-1:0]   w_cnt_next;

    assign w_is_signed = ~r_op[0];
    assign w_is_div    = r_op[1];

    // Sign- or zero-extend to 2*WIDTH; the low 2*WIDTH bits of the product of
    // the extended operands equal the full signed/unsigned product.
    assign w_ext_a = {{WIDTH{w_is_signed & r_a[WIDTH-1]}}, r_a};
    assign w_ext_b = {{WIDTH{w_is_signed & r_b[WIDTH-1]}}, r_b};
    assign w_prod  = w_ext_a * w_ext_b;

    // Signed divide on magnitudes. The most negative dividend has magnitude
    // 2^(WIDTH-1), which is still representable unsigned, so -2^(W-1) / -1
    // naturally yields quotient -2^(W-1) and remainder 0.
    assign w_neg_a      = w_is_signed & r_a[WIDTH-1];
    assign w_neg_b      = w_is_signed & r_b[WIDTH-1];
    assign w_mag_a      = w_neg_a ? -r_a : r_a;
    assign w_mag_b      = w_neg_b ? -r_b : r_b;
    assign w_b_zero     = (r_b == '0);
    // Keep the divider defined for a zero divisor; its result is discarded.
    assign w_mag_b_safe = w_b_zero ? WIDTH'(1) : w_mag_b;
    assign w_q_mag      = w_mag_a / w_mag_b_safe;
    assign w_r_mag      = w_mag_a % w_mag_b_safe;
    assign w_quot       = (w_neg_a ^ w_neg_b) ? -w_q_mag : w_q_mag;
    assign w_rem        = w_neg_a ? -w_r_mag : w_r_mag;

    assign w_md_start = start && (md_op[3:2] == 2'b00);
    assign w_run_len  = md_op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    assign w_cnt_next = r_cnt - CNT_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_op    <= 2'b00;
            r_a     <= '0;
            r_b     <= '0;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_md_start) begin
                        r_op    <= md_op[1:0];
                        r_a     <= D1;
                        r_b     <= D2;
                        r_cnt   <= w_run_len;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end else if (start && md_op == 4'd4) begin
                        r_lo <= D1;
                    end else if (start && md_op == 4'd5) begin
                        r_hi <= D1;
                    end
                end
                S_RUN: begin
                    // Any start during RUN (mt or md) is ignored here.
                    r_cnt <= w_cnt_next;
                    if (w_cnt_next == '0) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                        if (w_is_div) begin
                            if (!w_b_zero) begin
                                r_hi <= w_rem;
                                r_lo <= w_quot;
                            end
                        end else begin
                            r_hi <= w_prod[2*WIDTH-1:WIDTH];
                            r_lo <= w_prod[WIDTH-1:0];
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign HI     = r_hi;
    assign LO     = r_lo;
    assign md_out = (md_op == 4'd7) ? r_hi : r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit

module tb_muldiv_unit;

    logic        clk;
    logic        reset;

    logic        a_start;
    logic [3:0]  a_op;
    logic [31:0] a_d1, a_d2;
    logic        a_busy;
    logic [31:0] a_hi, a_lo, a_mdout;

    logic        b_start;
    logic [3:0]  b_op;
    logic [15:0] b_d1, b_d2;
    logic        b_busy;
    logic [15:0] b_hi, b_lo, b_mdout;

    int n_checks;
    int n_pass;
    int n;

    muldiv_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(8)) u_a (
        .clk(clk), .reset(reset), .start(a_start), .md_op(a_op),
        .D1(a_d1), .D2(a_d2), .busy(a_busy), .HI(a_hi), .LO(a_lo), .md_out(a_mdout)
    );

    muldiv_unit #(.WIDTH(16), .MULT_CYCLES(5), .DIV_CYCLES(3), .CNT_W(8)) u_b (
        .clk(clk), .reset(reset), .start(b_start), .md_op(b_op),
        .D1(b_d1), .D2(b_d2), .busy(b_busy), .HI(b_hi), .LO(b_lo), .md_out(b_mdout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset) begin
            assert (!(a_start && a_op < 4'd4 && a_busy))
                else $error("FAIL hazard: md start issued while busy");
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    task automatic issue_a(input logic [3:0] op, input logic [31:0] d1, input logic [31:0] d2);
        a_start = 1'b1;
        a_op    = op;
        a_d1    = d1;
        a_d2    = d2;
        tick();
        a_start = 1'b0;
        a_op    = 4'hF;
        a_d1    = 32'h5A5A_5A5A;
        a_d2    = 32'h0000_0001;
    endtask

    task automatic wait_a(output int cnt);
        cnt = 0;
        while (a_busy === 1'b1 && cnt < 100) begin
            cnt++;
            tick();
        end
    endtask

    task automatic wait_b(output int cnt);
        cnt = 0;
        while (b_busy === 1'b1 && cnt < 100) begin
            cnt++;
            tick();
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b1;
        a_start  = 1'b0; a_op = 4'hF; a_d1 = '0; a_d2 = '0;
        b_start  = 1'b0; b_op = 4'hF; b_d1 = '0; b_d2 = '0;
        tick();
        tick();
        reset = 1'b0;
        repeat (3) tick();
        check("reset_busy", {31'd0, a_busy}, 32'd0);
        check("reset_hi", a_hi, 32'd0);
        check("reset_lo", a_lo, 32'd0);
        check("reset_mdout", a_mdout, 32'd0);

        // mult -2 * 3
        issue_a(4'd0, 32'hFFFF_FFFE, 32'h0000_0003);
        wait_a(n);
        check("mult_busy_cycles", n, 32'd5);
        check("mult_hi", a_hi, 32'hFFFF_FFFF);
        check("mult_lo", a_lo, 32'hFFFF_FFFA);

        // multu same operands: 0x2_FFFF_FFFA
        issue_a(4'd1, 32'hFFFF_FFFE, 32'h0000_0003);
        wait_a(n);
        check("multu_busy_cycles", n, 32'd5);
        check("multu_hi", a_hi, 32'h0000_0002);
        check("multu_lo", a_lo, 32'hFFFF_FFFA);

        // div -7 / 2 = -3 rem -1
        issue_a(4'd2, 32'hFFFF_FFF9, 32'h0000_0002);
        wait_a(n);
        check("div_busy_cycles", n, 32'd10);
        check("div_lo", a_lo, 32'hFFFF_FFFD);
        check("div_hi", a_hi, 32'hFFFF_FFFF);

        // div 7 / -2 = -3 rem 1
        issue_a(4'd2, 32'h0000_0007, 32'hFFFF_FFFE);
        wait_a(n);
        check("div_negdivisor_lo", a_lo, 32'hFFFF_FFFD);
        check("div_negdivisor_hi", a_hi, 32'h0000_0001);

        // div overflow -2^31 / -1
        issue_a(4'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_a(n);
        check("div_ovf_lo", a_lo, 32'h8000_0000);
        check("div_ovf_hi", a_hi, 32'h0000_0000);

        // preset HI/LO, then divu by zero leaves them unchanged
        issue_a(4'd5, 32'h0000_0011, 32'h0);
        issue_a(4'd4, 32'h0000_0022, 32'h0);
        issue_a(4'd3, 32'h0000_0007, 32'h0000_0000);
        a_op = 4'd7;
        #1;
        check("divu0_mfhi_during_run", a_mdout, 32'h0000_0011);
        a_op = 4'hF;
        wait_a(n);
        check("divu0_busy_cycles", n, 32'd10);
        check("divu0_hi", a_hi, 32'h0000_0011);
        check("divu0_lo", a_lo, 32'h0000_0022);

        // mthi then mf reads
        issue_a(4'd5, 32'hABCD_0000, 32'h0);
        a_op = 4'd7;
        #1;
        check("mfhi_after_mthi", a_mdout, 32'hABCD_0000);
        a_op = 4'd6;
        #1;
        check("mflo_read", a_mdout, 32'h0000_0022);
        a_op = 4'hF;

        // back-to-back: second mult issued in the cycle busy falls
        issue_a(4'd0, 32'h0000_0002, 32'h0000_0003);
        wait_a(n);
        check("b2b_first_busy_cycles", n, 32'd5);
        check("b2b_busy_low_gap", {31'd0, a_busy}, 32'd0);
        check("b2b_first_hi", a_hi, 32'h0000_0000);
        check("b2b_first_lo", a_lo, 32'h0000_0006);
        issue_a(4'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("b2b_busy_rises", {31'd0, a_busy}, 32'd1);
        // mtlo during RUN is ignored
        issue_a(4'd4, 32'hDEAD_BEEF, 32'h0);
        check("mtlo_in_run_lo", a_lo, 32'h0000_0006);
        wait_a(n);
        check("b2b_second_remaining", n, 32'd4);
        check("b2b_second_hi", a_hi, 32'h0000_0000);
        check("b2b_second_lo", a_lo, 32'h0000_0001);

        // reset in cycle 3 of a running div
        issue_a(4'd2, 32'h0000_0064, 32'h0000_0007);
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("midrun_reset_busy", {31'd0, a_busy}, 32'd0);
        check("midrun_reset_hi", a_hi, 32'd0);
        check("midrun_reset_lo", a_lo, 32'd0);
        reset = 1'b0;
        tick();

        // narrow instance: WIDTH=16, DIV_CYCLES=3
        b_start = 1'b1;
        b_op    = 4'd2;
        b_d1    = 16'hFFF9;
        b_d2    = 16'h0002;
        tick();
        b_start = 1'b0;
        b_op    = 4'hF;
        b_d1    = 16'h1234;
        wait_b(n);
        check("w16_div_busy_cycles", n, 32'd3);
        check("w16_div_lo", {16'd0, b_lo}, 32'h0000_FFFD);
        check("w16_div_hi", {16'd0, b_hi}, 32'h0000_FFFF);
        b_op = 4'd7;
        #1;
        check("w16_mfhi", {16'd0, b_mdout}, 32'h0000_FFFF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
